parity_req_arbiter: RTL and testbench

Round-robin scheduler that shares one bit-serial parity engine among `NREQ` requesters. It accepts one `WIDTH`-bit word at a time over a valid/ready handshake and folds it through an XOR accumulator, one bit per cycle. It then returns the parity, the source ID and the original word on a held result port. It sits in front of the team's parity datapath so several producers can use a single generator without external muxing.

---
 rtl/parity_req_arbiter_if.sv | 27 ++
 rtl/parity_req_arbiter.sv | 120 ++++++++++++
 tb/tb_parity_req_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/parity_req_arbiter_if.sv
// Request/result bundle shared between the requesters, the result consumer and
// the parity arbiter. The arbiter uses the slave view; the traffic source uses master.
interface parity_req_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_parity;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      res_data;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_parity, res_id, res_data
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_parity, res_id, res_data
  );
endinterface

// File: rtl/parity_req_arbiter.sv
// Round-robin arbiter feeding one bit-serial parity engine shared by NREQ requesters.
//
// state | meaning
// IDLE  | waiting for a request; one-hot req_ready at the round-robin winner
// CALC  | folding the captured word into the XOR accumulator, LSB first
// RESP  | result held on the output port until res_ready
module parity_req_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter bit ODD   = 1'b0
) (
  input logic              clk,
  input logic              reset_n,
  parity_req_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             acc_q;
  logic [WIDTH-1:0] shreg_q;
  logic             res_valid_q;
  logic             res_parity_q;
  logic [IDW-1:0]   res_id_q;
  logic [WIDTH-1:0] res_data_q;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   ptr_d;
  logic [WIDTH-1:0] win_data;
  logic [NREQ-1:0]  grant;
  logic             acc_d;

  // Search from ptr upward (wrapping) for the first valid requester.
  always_comb begin
    logic [IDW:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!win_found && bus.req_valid[sum[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[IDW-1:0];
      end
    end
  end

  // Winner's data word, next pointer and the one-hot grant (never during reset).
  always_comb begin
    logic [IDW:0] nxt;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_data = bus.req_data[i*WIDTH +: WIDTH];
    end
    nxt = {1'b0, win_idx} + (IDW+1)'(1);
    if (nxt >= (IDW+1)'(NREQ)) nxt = '0;
    ptr_d = nxt[IDW-1:0];
    grant = '0;
    if (reset_n && state_q == IDLE && win_found) grant[win_idx] = 1'b1;
    acc_d = acc_q ^ shreg_q[0];
  end

  assign bus.req_ready  = grant;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_parity = res_parity_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_data   = res_data_q;

  // Sequencer: accept, serial fold, then hold the result until it is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      shreg_q      <= '0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= '0;
      res_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            shreg_q    <= win_data;
            res_data_q <= win_data;
            res_id_q   <= win_idx;
            acc_q      <= ODD;
            cnt_q      <= '0;
            ptr_q      <= ptr_d;
            state_q    <= CALC;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            res_parity_q <= acc_d;
            res_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_req_arbiter.sv
// Directed bench for parity_req_arbiter: reset, single request, round-robin,
// backpressure, reset mid-calculation and a full 8-bit parity sweep (even and odd).
module tb_parity_req_arbiter;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;

  parity_req_arbiter_if #(.WIDTH(8), .NREQ(4)) ifa ();
  parity_req_arbiter_if #(.WIDTH(8), .NREQ(4)) ifb ();

  parity_req_arbiter #(.WIDTH(8), .NREQ(4), .ODD(1'b0)) dut_even (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  parity_req_arbiter #(.WIDTH(8), .NREQ(4), .ODD(1'b1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input bit sel, output logic [3:0] g);
    int n;
    n = 0;
    g = sel ? ifb.req_ready : ifa.req_ready;
    while (g == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
      g = sel ? ifb.req_ready : ifa.req_ready;
    end
    checks++;
    assert (n < 40) else begin
      errors++;
      $error("FAIL grant_timeout observed=%0d cycles expected=<40", n);
    end
  endtask

  task automatic wait_res(input bit sel);
    int   n;
    logic v;
    n = 0;
    v = 1'b0;
    while (!v && n < 40) begin
      @(negedge clk);
      n++;
      v = sel ? ifb.res_valid : ifa.res_valid;
    end
    checks++;
    assert (n < 40) else begin
      errors++;
      $error("FAIL result_timeout observed=%0d cycles expected=<40", n);
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [7:0] wv;
    logic [7:0] dat [4];
    int         exp_id [5];
    logic       exp_par [5];
    int         prev_cyc;

    dat     = '{8'h01, 8'h03, 8'h07, 8'h00};
    exp_id  = '{0, 1, 2, 3, 0};
    exp_par = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    checks = 0; errors = 0; cyc = 0; prev_cyc = 0;

    reset_n = 1'b0;
    ifa.req_valid = 4'b1111; ifa.req_data = '0; ifa.res_ready = 1'b1;
    ifb.req_valid = 4'b0000; ifb.req_data = '0; ifb.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", ifa.req_ready, 4'b0000);
    chk("rst_res_valid", ifa.res_valid, 1'b0);

    // Single requester 1 with A5
    ifa.req_valid = 4'b0000;
    reset_n = 1'b1;
    @(negedge clk);
    ifa.req_valid = 4'b0010;
    ifa.req_data[15:8] = 8'hA5;
    #1;
    chk("single_grant", ifa.req_ready, 4'b0010);
    @(negedge clk);
    ifa.req_valid = 4'b0000;
    #1;
    chk("single_ready_drop", ifa.req_ready, 4'b0000);
    chk("single_lat0", ifa.res_valid, 1'b0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("single_lat", ifa.res_valid, 1'b0);
    end
    @(negedge clk);
    chk("single_valid", ifa.res_valid, 1'b1);
    chk("single_parity", ifa.res_parity, 1'b0);
    chk("single_id", ifa.res_id, 2'd1);
    chk("single_data", ifa.res_data, 8'hA5);
    @(negedge clk);
    chk("single_valid_fall", ifa.res_valid, 1'b0);

    // Backpressure: ptr is now 2, all requesters pending
    for (int i = 0; i < 4; i++) ifa.req_data[i*8 +: 8] = dat[i];
    ifa.req_valid = 4'b1111;
    ifa.res_ready = 1'b0;
    #1;
    chk("bp_grant", ifa.req_ready, 4'b0100);
    wait_res(1'b0);
    chk("bp_id", ifa.res_id, 2'd2);
    chk("bp_parity", ifa.res_parity, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", ifa.res_valid, 1'b1);
      chk("bp_hold_id", ifa.res_id, 2'd2);
      chk("bp_hold_data", ifa.res_data, 8'h07);
      chk("bp_no_grant", ifa.req_ready, 4'b0000);
    end
    ifa.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", ifa.req_ready, 4'b1000);
    chk("bp_release_valid", ifa.res_valid, 1'b0);
    ifa.res_ready = 1'b0;
    wait_res(1'b0);
    chk("bp2_id", ifa.res_id, 2'd3);
    chk("bp2_parity", ifa.res_parity, 1'b0);

    // Asynchronous reset while holding a result
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_res_valid", ifa.res_valid, 1'b0);
    chk("arst_res_id", ifa.res_id, 2'd0);
    chk("arst_res_parity", ifa.res_parity, 1'b0);
    chk("arst_res_data", ifa.res_data, 8'h00);
    chk("arst_req_ready", ifa.req_ready, 4'b0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ifa.res_ready = 1'b1;
    #1;

    // Round-robin with all four valid
    for (int i = 0; i < 5; i++) begin
      wait_grant(1'b0, g);
      chk("rr_grant", g, 4'b0001 << exp_id[i]);
      if (i > 0) chk("rr_spacing", cyc - prev_cyc, 10);
      prev_cyc = cyc;
      wait_res(1'b0);
      chk("rr_id", ifa.res_id, exp_id[i]);
      chk("rr_parity", ifa.res_parity, exp_par[i]);
      chk("rr_data", ifa.res_data, dat[exp_id[i]]);
    end

    // Reset three cycles into requester 2's calculation
    ifa.req_valid = 4'b1100;
    #1;
    wait_grant(1'b0, g);
    chk("mid_grant", g, 4'b0100);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", ifa.res_valid, 1'b0);
    chk("mid_rst_ready", ifa.req_ready, 4'b0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_after_valid", ifa.res_valid, 1'b0);
    chk("mid_after_grant", ifa.req_ready, 4'b0100);
    wait_res(1'b0);
    chk("mid_res_id", ifa.res_id, 2'd2);
    chk("mid_res_parity", ifa.res_parity, 1'b1);
    ifa.req_valid = 4'b0000;

    // Exhaustive even-parity sweep on requester 0
    for (int w = 0; w < 256; w++) begin
      wv = w[7:0];
      ifa.req_data[7:0] = wv;
      ifa.req_valid = 4'b0001;
      #1;
      wait_grant(1'b0, g);
      @(negedge clk);
      ifa.req_valid = 4'b0000;
      wait_res(1'b0);
      chk("sweep_even", ifa.res_parity, ^wv);
    end

    // Exhaustive odd-parity sweep on requester 0
    for (int w = 0; w < 256; w++) begin
      wv = w[7:0];
      ifb.req_data[7:0] = wv;
      ifb.req_valid = 4'b0001;
      #1;
      wait_grant(1'b1, g);
      @(negedge clk);
      ifb.req_valid = 4'b0000;
      wait_res(1'b1);
      chk("sweep_odd", ifb.res_parity, ~^wv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
